// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: mode constants and a width helper
// for callers that size N from a modulus.
package counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Number of bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control and status bundle of one mod_counter; the master drives commands,
// the slave (the counter) drives the count and its flags.
interface mod_counter_if #(
    parameter int N = 8
);
    logic         clear;
    logic         load;
    logic [N-1:0] d;
    logic         enable;
    logic         up;
    logic [N-1:0] q;
    logic         max_tick;
    logic         min_tick;
    logic         wrap;

    modport master (
        output clear, load, d, enable, up,
        input  q, max_tick, min_tick, wrap
    );

    modport slave (
        input  clear, load, d, enable, up,
        output q, max_tick, min_tick, wrap
    );
endinterface

// File: rtl/mod_counter_next.sv
// Combinational next-count step for a modulo-MOD counter: one step up or down
// with wrap or hold at the range ends, plus the at-end flag for the direction.
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int N        = 8,
    parameter int MOD      = 256,
    parameter int SATURATE = CNT_WRAP
) (
    input  logic [N-1:0] i_q,
    input  logic         i_up,
    output logic [N-1:0] o_next,
    output logic         o_at_end
);
    localparam logic [N:0] LP_MAX = (N+1)'(MOD - 1);
    localparam logic [N:0] LP_ONE = (N+1)'(1);

    logic [N:0] w_q_ext;
    logic [N:0] w_next_ext;
    logic       w_unused_msb;

    // One extra bit so MOD == 2^N never relies on natural overflow.
    assign w_q_ext  = {1'b0, i_q};
    assign o_at_end = i_up ? (w_q_ext == LP_MAX) : (w_q_ext == '0);

    always_comb begin
        w_next_ext = w_q_ext;
        if (!o_at_end) begin
            w_next_ext = i_up ? (w_q_ext + LP_ONE) : (w_q_ext - LP_ONE);
        end else if (SATURATE == CNT_WRAP) begin
            w_next_ext = i_up ? '0 : LP_MAX;
        end
    end

    assign o_next       = w_next_ext[N-1:0];
    assign w_unused_msb = w_next_ext[N];

endmodule

// File: rtl/mod_counter.sv
// Modulo-MOD up/down counter with clear, clamped load, wrap/saturate mode and
// terminal-count flags; `wrap` is meant to enable the next cascaded stage.
module mod_counter
    import counter_pkg::*;
#(
    parameter int N        = 8,
    parameter int MOD      = 256,
    parameter int SATURATE = CNT_WRAP
) (
    input  logic           clk,
    input  logic           reset,
    mod_counter_if.slave   bus
);
    localparam logic [N-1:0] LP_MAX_Q   = N'(MOD - 1);
    localparam logic         LP_WRAP_EN = (SATURATE == CNT_WRAP);

    if (MOD < 2 || 64'(MOD) > (64'd1 << N)) begin : g_bad_mod
        $error("mod_counter: MOD must satisfy 2 <= MOD <= 2**N");
    end

    logic [N-1:0] r_q;
    logic [N-1:0] w_step;
    logic         w_at_end;
    logic [N-1:0] w_load_val;
    logic [N-1:0] w_q_next;

    mod_counter_next #(
        .N        (N),
        .MOD      (MOD),
        .SATURATE (SATURATE)
    ) u_next (
        .i_q      (r_q),
        .i_up     (bus.up),
        .o_next   (w_step),
        .o_at_end (w_at_end)
    );

    // Out-of-range load values clamp to the top of the count range.
    assign w_load_val = (bus.d > LP_MAX_Q) ? LP_MAX_Q : bus.d;

    always_comb begin
        w_q_next = r_q;
        if (bus.clear) begin
            w_q_next = '0;
        end else if (bus.load) begin
            w_q_next = w_load_val;
        end else if (bus.enable) begin
            w_q_next = w_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign bus.q        = r_q;
    assign bus.max_tick = (r_q == LP_MAX_Q);
    assign bus.min_tick = (r_q == '0);
    assign bus.wrap     = LP_WRAP_EN & bus.enable & ~bus.clear & ~bus.load & w_at_end;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench: three counters (MOD=10 wrap, MOD=10 saturate, MOD=16 wrap)
// share one stimulus stream and are compared against an arithmetic reference model.
module tb_mod_counter;
    import counter_pkg::*;

    logic       clk;
    logic       reset;
    logic       in_clear;
    logic       in_load;
    logic       in_en;
    logic       in_up;
    logic [3:0] in_d;

    int n_tests;
    int n_fail;

    int mods [3] = '{10, 10, 16};
    bit sats [3] = '{1'b0, 1'b1, 1'b0};
    int m_q  [3];

    mod_counter_if #(.N(4)) bus_a ();
    mod_counter_if #(.N(4)) bus_s ();
    mod_counter_if #(.N(4)) bus_f ();

    assign bus_a.clear = in_clear;  assign bus_s.clear = in_clear;  assign bus_f.clear = in_clear;
    assign bus_a.load  = in_load;   assign bus_s.load  = in_load;   assign bus_f.load  = in_load;
    assign bus_a.enable = in_en;    assign bus_s.enable = in_en;    assign bus_f.enable = in_en;
    assign bus_a.up    = in_up;     assign bus_s.up    = in_up;     assign bus_f.up    = in_up;
    assign bus_a.d     = in_d;      assign bus_s.d     = in_d;      assign bus_f.d     = in_d;

    mod_counter #(.N(4), .MOD(10), .SATURATE(CNT_WRAP)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    mod_counter #(.N(4), .MOD(10), .SATURATE(CNT_SAT))  dut_s (.clk(clk), .reset(reset), .bus(bus_s));
    mod_counter #(.N(4), .MOD(16), .SATURATE(CNT_WRAP)) dut_f (.clk(clk), .reset(reset), .bus(bus_f));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Reference: the counting rules written as plain modular arithmetic.
    function automatic int model_next(input int q, input int m, input bit sat,
                                      input bit c, input bit l, input bit e,
                                      input bit u, input int d);
        if (c) return 0;
        if (l) return (d > m - 1) ? m - 1 : d;
        if (!e) return q;
        if (u) begin
            if (sat) return (q + 1 > m - 1) ? q : q + 1;
            return (q + 1) % m;
        end
        if (sat) return (q == 0) ? 0 : q - 1;
        return (q + m - 1) % m;
    endfunction

    task automatic check_val(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (%b) expected %0d", name, act, act, exp);
        end
    endtask

    task automatic check_dut(input int i, input string tag);
        logic [3:0] aq;
        logic       amax, amin, awrap;
        int         eq;
        logic       emax, emin, ewrap;
        case (i)
            0:       begin aq = bus_a.q; amax = bus_a.max_tick; amin = bus_a.min_tick; awrap = bus_a.wrap; end
            1:       begin aq = bus_s.q; amax = bus_s.max_tick; amin = bus_s.min_tick; awrap = bus_s.wrap; end
            default: begin aq = bus_f.q; amax = bus_f.max_tick; amin = bus_f.min_tick; awrap = bus_f.wrap; end
        endcase
        eq    = m_q[i];
        emax  = (eq == mods[i] - 1);
        emin  = (eq == 0);
        ewrap = !sats[i] && in_en && !in_clear && !in_load && ((in_up && emax) || (!in_up && emin));
        check_val($sformatf("%s[%0d].q", tag, i),        aq,              4'(eq));
        check_val($sformatf("%s[%0d].max_tick", tag, i), {3'b0, amax},    {3'b0, emax});
        check_val($sformatf("%s[%0d].min_tick", tag, i), {3'b0, amin},    {3'b0, emin});
        check_val($sformatf("%s[%0d].wrap", tag, i),     {3'b0, awrap},   {3'b0, ewrap});
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) check_dut(i, tag);
    endtask

    task automatic set_in(input bit c, input bit l, input bit e, input bit u, input logic [3:0] d);
        in_clear = c; in_load = l; in_en = e; in_up = u; in_d = d;
    endtask

    task automatic step();
        int nq [3];
        for (int i = 0; i < 3; i++)
            nq[i] = model_next(m_q[i], mods[i], sats[i], in_clear, in_load, in_en, in_up, int'(in_d));
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) m_q[i] = nq[i];
    endtask

    typedef struct {
        bit         clr;
        bit         ld;
        bit         en;
        bit         up;
        logic [3:0] d;
        int         exp_q;
        bit         exp_wrap;
    } vec_t;

    vec_t vecs [19];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 3; i++) m_q[i] = 0;
        set_in(0, 0, 0, 0, 4'd0);
        reset = 1'b1;

        // Expected results for the MOD=10 wrapping counter.
        for (int i = 0; i < 12; i++) begin
            vecs[i] = '{clr: 0, ld: 0, en: 1, up: 1, d: 4'd0,
                        exp_q: (i + 1) % 10, exp_wrap: ((i + 1) % 10 == 9)};
        end
        vecs[12] = '{clr: 0, ld: 1, en: 0, up: 1, d: 4'd6,  exp_q: 6, exp_wrap: 0};
        vecs[13] = '{clr: 0, ld: 1, en: 0, up: 1, d: 4'd13, exp_q: 9, exp_wrap: 0};
        vecs[14] = '{clr: 0, ld: 1, en: 1, up: 1, d: 4'd3,  exp_q: 3, exp_wrap: 0};
        vecs[15] = '{clr: 1, ld: 1, en: 1, up: 1, d: 4'd5,  exp_q: 0, exp_wrap: 0};
        vecs[16] = '{clr: 0, ld: 0, en: 1, up: 0, d: 4'd0,  exp_q: 9, exp_wrap: 0};
        vecs[17] = '{clr: 0, ld: 0, en: 1, up: 0, d: 4'd0,  exp_q: 8, exp_wrap: 0};
        vecs[18] = '{clr: 0, ld: 0, en: 1, up: 0, d: 4'd0,  exp_q: 7, exp_wrap: 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #2 reset = 1'b0;

        // Table: wrap-up, load clamp/priority, wrap-down
        foreach (vecs[k]) begin
            set_in(vecs[k].clr, vecs[k].ld, vecs[k].en, vecs[k].up, vecs[k].d);
            #1;
            check_all($sformatf("pre%0d", k));
            step();
            check_all($sformatf("vec%0d", k));
            check_val($sformatf("vec%0d.a_q", k), bus_a.q, 4'(vecs[k].exp_q));
            check_val($sformatf("vec%0d.a_wrap", k), {3'b0, bus_a.wrap}, {3'b0, vecs[k].exp_wrap});
        end

        // Wrap-down flag while sitting at zero
        set_in(1, 0, 0, 0, 4'd0);
        step();
        set_in(0, 0, 1, 0, 4'd0);
        #1;
        check_val("down_at0.a_wrap", {3'b0, bus_a.wrap}, 4'd1);
        check_val("down_at0.a_min", {3'b0, bus_a.min_tick}, 4'd1);
        check_all("down_at0");

        // Saturate: up from 8, down from 1
        set_in(0, 1, 0, 1, 4'd8);
        step();
        set_in(0, 0, 1, 1, 4'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_val($sformatf("sat_up%0d.q", k), bus_s.q, 4'd9);
            check_val($sformatf("sat_up%0d.wrap", k), {3'b0, bus_s.wrap}, 4'd0);
            check_all("sat_up");
        end
        set_in(0, 1, 0, 0, 4'd1);
        step();
        set_in(0, 0, 1, 0, 4'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            check_val($sformatf("sat_dn%0d.q", k), bus_s.q, 4'd0);
            check_val($sformatf("sat_dn%0d.wrap", k), {3'b0, bus_s.wrap}, 4'd0);
            check_all("sat_dn");
        end

        // Async reset mid-count, between clock edges
        set_in(0, 1, 1, 1, 4'd7);
        step();
        check_val("pre_rst.a_q", bus_a.q, 4'd7);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) m_q[i] = 0;
        check_val("async_rst.a_q", bus_a.q, 4'd0);
        check_all("async_rst");
        #2 reset = 1'b0;
        set_in(0, 0, 1, 1, 4'd0);
        step();
        check_val("resume1.a_q", bus_a.q, 4'd1);
        step();
        check_val("resume2.a_q", bus_a.q, 4'd2);
        check_all("resume");

        // Full-range modulus 16
        set_in(0, 1, 0, 1, 4'd15);
        step();
        set_in(0, 0, 1, 1, 4'd0);
        #1;
        check_val("full_up.f_wrap", {3'b0, bus_f.wrap}, 4'd1);
        check_val("full_up.f_max", {3'b0, bus_f.max_tick}, 4'd1);
        step();
        check_val("full_up.f_q", bus_f.q, 4'd0);
        set_in(0, 0, 1, 0, 4'd0);
        #1;
        check_val("full_dn.f_wrap", {3'b0, bus_f.wrap}, 4'd1);
        step();
        check_val("full_dn.f_q", bus_f.q, 4'd15);
        check_all("full");

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            set_in($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)));
            #1;
            check_all("rnd_pre");
            step();
            check_all("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
